histo_run_controller: RTL and testbench
=======================================

// Module: histo_run_controller
// PURPOSE
//  Sequences one run-length histogram measurement: init -> capture -> flush -> readout.
//  Pulses hist_init, then forwards exactly FRAME_BITS contiguous bits with data_valid held high.
//  Then sweeps hist_addr over all bins and streams each count out on a valid/ready port.
//  Sits between the bit source / SW control and the histogram datapath, which it owns exclusively.
// PARAMETERS
//  FRAME_BITS   1024  bits per measurement frame
//  NUM_BINS     16    histogram bins swept in readout (addr width = $clog2(NUM_BINS))
//  COUNT_W      10    width of hist_rdata / rd_count
//  INIT_CYCLES  2     cycles hist_init held high (>=1)
//  FLUSH_CYCLES 2     idle cycles after last bit before readout starts (datapath commit)
// PORTS
//  clk          in   1        clock; all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        pulse; accepted only in IDLE or DONE
//  abort        in   1        any state -> IDLE next cycle; outputs return to reset values
//  bit_in       in   1        source data bit
//  bit_in_valid in   1        source bit present
//  bit_in_ready out  1        high only in CAPTURE
//  hist_init    out  1        histogram init strobe
//  hist_valid   out  1        histogram data_valid
//  hist_din     out  1        histogram data_in (registered copy of bit_in)
//  hist_addr    out  4        histogram bin select
//  hist_rdata   in   COUNT_W  histogram bin count, valid 1 cycle after hist_addr
//  rd_valid     out  1        readout beat valid
//  rd_ready     in   1        readout consumer ready
//  rd_bin       out  4        bin index of current beat
//  rd_count     out  COUNT_W  bin count of current beat
//  busy         out  1        state != IDLE and != DONE
//  done         out  1        1-cycle pulse on entry to DONE
//  err          out  1        sticky; source gap in CAPTURE; cleared by rst or accepted start
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; bit counter, bin index and flush counter 0.
//  Transitions:
//   IDLE/DONE --start--> INIT.
//   INIT: hist_init=1 for INIT_CYCLES cycles -> CAPTURE.
//   CAPTURE: bit_in_ready=1. Each beat (bit_in_valid&bit_in_ready) registers
//    hist_din<=bit_in, hist_valid<=1, and increments bit_cnt.
//    Forwarding latency is exactly 1 cycle.
//    On the FRAME_BITS-th beat -> FLUSH; hist_valid drops the cycle after the last bit is driven.
//    bit_in_valid low in CAPTURE -> err<=1, hist_valid<=0, -> IDLE. No readout.
//   FLUSH: hist_valid=0 for FLUSH_CYCLES cycles -> READOUT with bin=0.
//   READOUT (per bin):
//    Drive hist_addr=bin and wait 1 cycle.
//    Register rd_count<=hist_rdata, rd_bin<=bin, rd_valid<=1.
//    Hold rd_valid/rd_bin/rd_count stable until rd_ready; beat completes on rd_valid&rd_ready.
//    Next cycle drive bin+1. Bin NUM_BINS-1 handshake -> DONE; done pulse; rd_valid<=0.
//   DONE: holds until start.
//  Arithmetic: bit_cnt width $clog2(FRAME_BITS)+1, no wrap inside a frame. bin never exceeds NUM_BINS-1.
//  Ignored inputs: start outside IDLE/DONE. bit_in outside CAPTURE.
//  hist_addr is held at 0 outside READOUT.
//  Simultaneous events:
//   abort wins over start and every handshake.
//   rst wins over abort.
//   start with abort -> IDLE.
//  rd_ready high with rd_valid low has no effect.
// TESTING
//  1. rst, start, 1024 bits alternating 1/0 -> hist_init 2 cycles; hist_valid 1024 contiguous cycles;
//     16 beats bin 0..15; bin1 rd_count = datapath count; done once.
//  2. rd_ready held low 5 cycles on bin 3 -> rd_valid/rd_bin=3/rd_count stable; hist_addr stays 3.
//  3. bit_in_valid dropped at bit 500 -> err=1, state IDLE, no rd_valid.
//     Next start clears err.
//  4. abort during READOUT bin 7 -> next cycle busy=0, rd_valid=0, hist_addr=0; no done.
//  5. start pulsed during CAPTURE -> ignored; exactly 1024 beats accepted.
//  6. start asserted in DONE -> new run; hist_init reasserted; counters restart at 0.

Source files
------------

// File: rtl/histo_run_controller_if.sv
// Bit-source and readout-stream handshake bundle for histo_run_controller.
// The slave modport is the controller side; the master modport is the source/consumer side.
interface histo_run_controller_if #(
  parameter int unsigned COUNT_W = 10,
  parameter int unsigned ADDR_W  = 4
);
  logic               bit_in;
  logic               bit_in_valid;
  logic               bit_in_ready;
  logic               rd_valid;
  logic               rd_ready;
  logic [ADDR_W-1:0]  rd_bin;
  logic [COUNT_W-1:0] rd_count;

  modport master (
    output bit_in, bit_in_valid, rd_ready,
    input  bit_in_ready, rd_valid, rd_bin, rd_count
  );

  modport slave (
    input  bit_in, bit_in_valid, rd_ready,
    output bit_in_ready, rd_valid, rd_bin, rd_count
  );
endinterface

// File: rtl/histo_run_controller.sv
// Sequences one run-length histogram measurement: init, capture one frame of bits,
// flush the datapath, then read every bin out over a valid/ready stream.
module histo_run_controller #(
  parameter int unsigned FRAME_BITS   = 1024,
  parameter int unsigned NUM_BINS     = 16,
  parameter int unsigned COUNT_W      = 10,
  parameter int unsigned INIT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  localparam int unsigned ADDR_W      = $clog2(NUM_BINS)
) (
  input  logic                clk,
  input  logic                rst,
  histo_run_controller_if.slave bus,
  input  logic                start,
  input  logic                abort,
  output logic                hist_init,
  output logic                hist_valid,
  output logic                hist_din,
  output logic [ADDR_W-1:0]   hist_addr,
  input  logic [COUNT_W-1:0]  hist_rdata,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned BC_W  = $clog2(FRAME_BITS) + 1;
  localparam int unsigned CNT_W = $clog2(INIT_CYCLES + FLUSH_CYCLES + 2);

  localparam logic [BC_W-1:0]   FRAME_LAST = BC_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  // The first FLUSH cycle still presents the last bit, so FLUSH_CYCLES idle cycles follow it.
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYCLES);
  localparam logic [ADDR_W-1:0] BIN_LAST   = ADDR_W'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CAPTURE,
    S_FLUSH,
    S_RD_ADDR,
    S_RD_LATCH,
    S_RD_HOLD,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] bin;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_bin_q;
  logic [COUNT_W-1:0] rd_count_q;
  logic              in_readout;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_INIT;
      S_INIT:         if (cnt == INIT_LAST) state_next = S_CAPTURE;
      S_CAPTURE: begin
        if (!bus.bit_in_valid)          state_next = S_IDLE;
        else if (bit_cnt == FRAME_LAST) state_next = S_FLUSH;
      end
      S_FLUSH:        if (cnt == FLUSH_LAST) state_next = S_RD_ADDR;
      S_RD_ADDR:      state_next = S_RD_LATCH;
      S_RD_LATCH:     state_next = S_RD_HOLD;
      S_RD_HOLD: begin
        if (bus.rd_ready) state_next = (bin == BIN_LAST) ? S_DONE : S_RD_ADDR;
      end
      default:        state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_comb begin
    in_readout       = (state == S_RD_ADDR) || (state == S_RD_LATCH) || (state == S_RD_HOLD);
    bus.bit_in_ready = (state == S_CAPTURE);
    hist_init        = (state == S_INIT);
    busy             = (state != S_IDLE) && (state != S_DONE);
    hist_addr        = in_readout ? bin : '0;
    bus.rd_valid     = rd_valid_q;
    bus.rd_bin       = rd_bin_q;
    bus.rd_count     = rd_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      cnt        <= '0;
      bin        <= '0;
      hist_valid <= 1'b0;
      hist_din   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bin_q   <= '0;
      rd_count_q <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (abort) begin
        bit_cnt    <= '0;
        cnt        <= '0;
        bin        <= '0;
        hist_valid <= 1'b0;
        hist_din   <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_bin_q   <= '0;
        rd_count_q <= '0;
        err        <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              err     <= 1'b0;
              cnt     <= '0;
              bit_cnt <= '0;
              bin     <= '0;
            end
          end
          S_INIT: cnt <= (cnt == INIT_LAST) ? '0 : cnt + CNT_W'(1);
          S_CAPTURE: begin
            if (bus.bit_in_valid) begin
              hist_din   <= bus.bit_in;
              hist_valid <= 1'b1;
              bit_cnt    <= bit_cnt + BC_W'(1);
            end else begin
              err        <= 1'b1;
              hist_valid <= 1'b0;
            end
          end
          S_FLUSH: begin
            hist_valid <= 1'b0;
            bin        <= '0;
            cnt        <= (cnt == FLUSH_LAST) ? '0 : cnt + CNT_W'(1);
          end
          S_RD_LATCH: begin
            rd_count_q <= hist_rdata;
            rd_bin_q   <= bin;
            rd_valid_q <= 1'b1;
          end
          S_RD_HOLD: begin
            if (bus.rd_ready) begin
              rd_valid_q <= 1'b0;
              if (bin == BIN_LAST) done <= 1'b1;
              else                 bin  <= bin + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_histo_run_controller.sv
// Bench for histo_run_controller: a run-length histogram datapath model answers hist_addr,
// expected readout beats are queued per frame and compared as the DUT hands them over.
module tb_histo_run_controller;

  localparam int unsigned FRAME_BITS = 1024;
  localparam int unsigned NUM_BINS   = 16;
  localparam int unsigned COUNT_W    = 10;
  localparam int unsigned ADDR_W     = 4;
  localparam int          CNT_MAX    = (1 << COUNT_W) - 1;
  localparam int          LIMIT      = 3000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic hist_init;
  logic hist_valid;
  logic hist_din;
  logic [ADDR_W-1:0]  hist_addr;
  logic [COUNT_W-1:0] hist_rdata;
  logic busy;
  logic done;
  logic err;

  histo_run_controller_if #(.COUNT_W(COUNT_W), .ADDR_W(ADDR_W)) bus ();

  histo_run_controller #(
    .FRAME_BITS  (FRAME_BITS),
    .NUM_BINS    (NUM_BINS),
    .COUNT_W     (COUNT_W),
    .INIT_CYCLES (2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .start     (start),
    .abort     (abort),
    .hist_init (hist_init),
    .hist_valid(hist_valid),
    .hist_din  (hist_din),
    .hist_addr (hist_addr),
    .hist_rdata(hist_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int bin_of(input int run);
    return (run > NUM_BINS - 1) ? NUM_BINS - 1 : run;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (int'(v) >= CNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

  // Run-length histogram datapath: a run is committed when the bit changes or the stream ends.
  logic [COUNT_W-1:0] dp_mem [NUM_BINS];
  int   dp_run = 0;
  logic dp_prev = 1'b0;
  logic dp_have = 1'b0;

  always @(posedge clk) begin
    hist_rdata <= dp_mem[hist_addr];
    if (hist_init) begin
      for (int i = 0; i < NUM_BINS; i++) dp_mem[i] <= '0;
      dp_have <= 1'b0;
      dp_run  <= 0;
    end else if (hist_valid) begin
      if (dp_have && hist_din != dp_prev) begin
        dp_mem[bin_of(dp_run)] <= sat_inc(dp_mem[bin_of(dp_run)]);
        dp_run <= 1;
      end else begin
        dp_run <= dp_run + 1;
      end
      dp_prev <= hist_din;
      dp_have <= 1'b1;
    end else if (dp_have) begin
      dp_mem[bin_of(dp_run)] <= sat_inc(dp_mem[bin_of(dp_run)]);
      dp_have <= 1'b0;
    end
  end

  typedef struct {
    int bin;
    int count;
  } beat_t;

  beat_t exp_q[$];
  bit    frame_bits [FRAME_BITS];

  // pattern 0: alternating 1/0; pattern 1: random run lengths 1..20
  task automatic run_frame(input int pattern, input int drop_at, input int stall_bin,
                           input int abort_bin, input bit poke_start);
    int    h [NUM_BINS];
    int    run, idx, init_seen, valid_seen, valid_segs, done_seen, beats, rdv_seen;
    int    stall_left, quiet, len;
    bit    prev_valid, finished, aborted, beat, hs, b, full;
    logic [ADDR_W-1:0]  snap_bin;
    logic [COUNT_W-1:0] snap_cnt;
    beat_t e;

    full = (drop_at < 0) && (abort_bin < 0);
    idx = 0;
    if (pattern == 0) begin
      for (int i = 0; i < FRAME_BITS; i++) frame_bits[i] = (i % 2 == 0);
    end else begin
      b = 1'($urandom_range(0, 1));
      while (idx < FRAME_BITS) begin
        len = $urandom_range(1, 20);
        for (int k = 0; k < len && idx < FRAME_BITS; k++) begin
          frame_bits[idx] = b;
          idx++;
        end
        b = !b;
      end
    end

    for (int i = 0; i < NUM_BINS; i++) h[i] = 0;
    run = 1;
    for (int i = 1; i < FRAME_BITS; i++) begin
      if (frame_bits[i] != frame_bits[i-1]) begin
        if (h[bin_of(run)] < CNT_MAX) h[bin_of(run)]++;
        run = 1;
      end else begin
        run++;
      end
    end
    if (h[bin_of(run)] < CNT_MAX) h[bin_of(run)]++;
    if (drop_at < 0) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        e.bin = i;
        e.count = h[i];
        exp_q.push_back(e);
      end
    end

    idx = 0; init_seen = 0; valid_seen = 0; valid_segs = 0; done_seen = 0;
    beats = 0; rdv_seen = 0; quiet = 0; prev_valid = 0; finished = 0; aborted = 0;
    stall_left = (stall_bin >= 0) ? 5 : 0;
    snap_bin = '0; snap_cnt = '0;

    bus.bit_in = frame_bits[0];
    bus.bit_in_valid = 1'b1;
    bus.rd_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_err_clear", err, 0);
    check("start_busy", busy, 1);

    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      if (hist_init) init_seen++;
      if (hist_valid) valid_seen++;
      if (hist_valid && !prev_valid) valid_segs++;
      prev_valid = hist_valid;
      if (bus.rd_valid) rdv_seen++;
      if (done) begin
        done_seen++;
        finished = 1;
      end
      if (aborted) finished = 1;
      if (err && !busy) begin
        quiet++;
        if (quiet == 20) finished = 1;
      end
      if (finished) break;

      bus.bit_in = frame_bits[(idx < FRAME_BITS) ? idx : FRAME_BITS - 1];
      bus.bit_in_valid = (idx != drop_at);
      start = poke_start && bus.bit_in_ready && (idx == 300);
      abort = 1'b0;
      bus.rd_ready = 1'b1;
      if (bus.rd_valid && int'(bus.rd_bin) == stall_bin && stall_left > 0) begin
        if (stall_left == 5) begin
          snap_bin = bus.rd_bin;
          snap_cnt = bus.rd_count;
        end else begin
          check("stall_rd_valid", bus.rd_valid, 1);
          check("stall_rd_bin", bus.rd_bin, snap_bin);
          check("stall_rd_count", bus.rd_count, snap_cnt);
        end
        check("stall_hist_addr", hist_addr, stall_bin);
        bus.rd_ready = 1'b0;
        stall_left--;
      end
      if (abort_bin >= 0 && bus.rd_valid && int'(bus.rd_bin) == abort_bin) abort = 1'b1;
      hs = bus.rd_valid && bus.rd_ready && !abort;
      if (hs) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rd_bin", bus.rd_bin, e.bin);
          check("rd_count", bus.rd_count, e.count);
        end
      end
      beat = bus.bit_in_ready && bus.bit_in_valid;

      @(posedge clk); #1;
      start = 1'b0;
      if (beat) idx++;
      if (abort) begin
        abort = 1'b0;
        aborted = 1;
        check("abort_busy", busy, 0);
        check("abort_rd_valid", bus.rd_valid, 0);
        check("abort_hist_addr", hist_addr, 0);
        check("abort_pending_beats", exp_q.size(), NUM_BINS - abort_bin);
        exp_q.delete();
      end
    end
    if (!finished) check("run_timeout", 0, 1);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
      if (bus.rd_valid) rdv_seen++;
    end

    if (full) begin
      check("init_cycles", init_seen, 2);
      check("valid_cycles", valid_seen, FRAME_BITS);
      check("valid_segments", valid_segs, 1);
      check("bits_accepted", idx, FRAME_BITS);
      check("beats", beats, NUM_BINS);
      check("done_pulses", done_seen, 1);
      check("queue_empty", exp_q.size(), 0);
      check("end_busy", busy, 0);
      check("end_err", err, 0);
    end else if (drop_at >= 0) begin
      check("drop_err", err, 1);
      check("drop_busy", busy, 0);
      check("drop_valid_cycles", valid_seen, drop_at);
      check("drop_rd_valid", rdv_seen, 0);
      check("drop_done", done_seen, 0);
    end else begin
      check("abort_beats", beats, abort_bin);
      check("abort_done", done_seen, 0);
      check("abort_end_busy", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_in_valid = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_hist_init", hist_init, 0);
    check("rst_hist_valid", hist_valid, 0);
    check("rst_hist_din", hist_din, 0);
    check("rst_hist_addr", hist_addr, 0);
    check("rst_bit_in_ready", bus.bit_in_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_bin", bus.rd_bin, 0);
    check("rst_rd_count", bus.rd_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(0, -1, -1, -1, 0);
    run_frame(1, -1,  3, -1, 0);
    run_frame(1, 500, -1, -1, 0);
    run_frame(1, -1, -1, -1, 1);
    run_frame(1, -1, -1,  7, 0);
    run_frame(1, -1, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
